wb_regfile: RTL and testbench

- Architectural register file at the receiving end of the write-back stage.
- Consumes the registered write triple (data, address, enable) from the MEM→WB pipeline register.
- Serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Also holds the HI/LO special registers, written from the write-back stage and read by decode.

---
 rtl/wb_regfile_pkg.sv | 39 +++
 rtl/wb_regfile_hilo_reg.sv | 52 +++++
 rtl/wb_regfile.sv | 96 +++++++++
 tb/tb_wb_regfile.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants and read-source selection for the write-back register file.
// Default widths match the 32-bit datapath (32 GPRs, 5-bit indices).
package wb_regfile_pkg;

    localparam int REG_DATA_BUS = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int REG_COUNT    = 32;

    localparam logic [REG_DATA_BUS-1:0] ZERO_WORD     = '0;
    localparam logic [REG_ADDR_BUS-1:0] ZERO_REG_ADDR = 5'd0;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_BYPASS,
        SRC_STORE
    } read_src_e;

    // Priority: reset, disabled port, r0, same-cycle write hit, then storage.
    function automatic read_src_e readSource(
        input logic rst,
        input logic portEnabled,
        input logic addrIsZero,
        input logic bypassHit
    );
        read_src_e src;
        if (rst || !portEnabled || addrIsZero) begin
            src = SRC_ZERO;
        end else if (bypassHit) begin
            src = SRC_BYPASS;
        end else begin
            src = SRC_STORE;
        end
        return src;
    endfunction

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO special registers: written as a pair from write-back, read by decode
// with a bypass of the pair being written this cycle.
module hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_BUS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  whilo_i,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  writeHiLo;

    assign writeHiLo = (whilo_i == WRITE_ENABLE);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (writeHiLo) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= DATA_WIDTH'(ZERO_WORD);
            lo_q <= DATA_WIDTH'(ZERO_WORD);
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Outputs are forced to zero throughout reset, not just after it.
    always_comb begin
        hi_o = DATA_WIDTH'(ZERO_WORD);
        lo_o = DATA_WIDTH'(ZERO_WORD);
        if (!rst) begin
            hi_o = writeHiLo ? hi_i : hi_q;
            lo_o = writeHiLo ? lo_i : lo_q;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural GPR file fed by the MEM->WB write triple, with two combinational
// read ports (write bypass, r0 hardwired to zero) and the HI/LO pair.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_BUS,
    parameter int ADDR_WIDTH = REG_ADDR_BUS,
    parameter int REG_NUM    = REG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_write_en,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic                  wb_whilo,
    input  logic [DATA_WIDTH-1:0] wb_hi,
    input  logic [DATA_WIDTH-1:0] wb_lo,
    input  logic                  read1_en,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    output logic [DATA_WIDTH-1:0] read1_data,
    input  logic                  read2_en,
    input  logic [ADDR_WIDTH-1:0] read2_addr,
    output logic [DATA_WIDTH-1:0] read2_data,
    output logic [DATA_WIDTH-1:0] hi_data,
    output logic [DATA_WIDTH-1:0] lo_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(ZERO_REG_ADDR);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(ZERO_WORD);

    logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
    logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

    logic                  gprWrite;
    logic                  readEn   [2];
    logic [ADDR_WIDTH-1:0] readAddr [2];
    logic [DATA_WIDTH-1:0] readData [2];
    read_src_e             readSrc  [2];

    assign gprWrite = (wb_write_en == WRITE_ENABLE) && (wb_write_addr != ADDR_ZERO);

    // r0 is never written so it stays at its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (gprWrite) begin
            regs_d[wb_write_addr] = wb_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= DATA_ZERO;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign readEn[0]   = read1_en;
    assign readEn[1]   = read2_en;
    assign readAddr[0] = read1_addr;
    assign readAddr[1] = read2_addr;

    // Each port resolves on its own; both may hit the same or the written index.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            readSrc[p] = readSource(rst,
                                    readEn[p] == READ_ENABLE,
                                    readAddr[p] == ADDR_ZERO,
                                    (wb_write_en == WRITE_ENABLE) && (wb_write_addr == readAddr[p]));
            readData[p] = DATA_ZERO;
            unique case (readSrc[p])
                SRC_BYPASS: readData[p] = wb_write_data;
                SRC_STORE:  readData[p] = regs_q[readAddr[p]];
                default:    readData[p] = DATA_ZERO;
            endcase
        end
    end

    assign read1_data = readData[0];
    assign read2_data = readData[1];

    hilo_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .whilo_i (wb_whilo),
        .hi_i    (wb_hi),
        .lo_i    (wb_lo),
        .hi_o    (hi_data),
        .lo_o    (lo_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against an array-based model of the register file.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_write_en;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        read1_en;
    logic [4:0]  read1_addr;
    logic [31:0] read1_data;
    logic        read2_en;
    logic [4:0]  read2_addr;
    logic [31:0] read2_data;
    logic [31:0] hi_data;
    logic [31:0] lo_data;

    logic [31:0] modelRegs [32];
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .wb_write_en   (wb_write_en),
        .wb_write_addr (wb_write_addr),
        .wb_write_data (wb_write_data),
        .wb_whilo      (wb_whilo),
        .wb_hi         (wb_hi),
        .wb_lo         (wb_lo),
        .read1_en      (read1_en),
        .read1_addr    (read1_addr),
        .read1_data    (read1_data),
        .read2_en      (read2_en),
        .read2_addr    (read2_addr),
        .read2_data    (read2_data),
        .hi_data       (hi_data),
        .lo_data       (lo_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // What a decode-stage read should see given the inputs currently applied.
    function automatic logic [31:0] expectRead(input logic en, input logic [4:0] addr);
        if (rst || !en || addr == 5'd0) return 32'h0;
        if (wb_write_en && wb_write_addr == addr) return wb_write_data;
        return modelRegs[addr];
    endfunction

    // Drive one cycle of inputs, check all outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(
        input string       tag,
        input logic        r,
        input logic        we,
        input logic [4:0]  wa,
        input logic [31:0] wd,
        input logic        whl,
        input logic [31:0] h,
        input logic [31:0] l,
        input logic        r1e,
        input logic [4:0]  r1a,
        input logic        r2e,
        input logic [4:0]  r2a
    );
        rst = r; wb_write_en = we; wb_write_addr = wa; wb_write_data = wd;
        wb_whilo = whl; wb_hi = h; wb_lo = l;
        read1_en = r1e; read1_addr = r1a; read2_en = r2e; read2_addr = r2a;
        #2;
        checkOutput({tag, " read1"}, read1_data, expectRead(r1e, r1a));
        checkOutput({tag, " read2"}, read2_data, expectRead(r2e, r2a));
        checkOutput({tag, " hi"}, hi_data, r ? 32'h0 : (whl ? h : modelHi));
        checkOutput({tag, " lo"}, lo_data, r ? 32'h0 : (whl ? l : modelLo));
        @(posedge clk);
        if (r) begin
            foreach (modelRegs[i]) modelRegs[i] = 32'h0;
            modelHi = 32'h0;
            modelLo = 32'h0;
        end else begin
            if (we && wa != 5'd0) modelRegs[wa] = wd;
            if (whl) begin
                modelHi = h;
                modelLo = l;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (modelRegs[i]) modelRegs[i] = 32'h0;
        modelHi = 32'h0;
        modelLo = 32'h0;
        @(negedge clk);

        applyStimulus("initReset", 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
        applyStimulus("preload", 0, 1, 5, 32'h1234, 1, 32'hAA, 32'h0, 1, 5, 1, 0);
        applyStimulus("preloadHold", 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 5);
        applyStimulus("resetActive", 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
        applyStimulus("afterReset", 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);

        applyStimulus("writeR3", 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("readR3", 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3);

        applyStimulus("setR7", 0, 1, 7, 32'h1, 0, 0, 0, 1, 7, 1, 7);
        applyStimulus("bypassR7", 0, 1, 7, 32'h55AA55AA, 0, 0, 0, 1, 7, 1, 7);
        applyStimulus("storedR7", 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7);

        applyStimulus("writeR0", 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0);
        applyStimulus("readR0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

        applyStimulus("hiloWrite", 0, 0, 0, 0, 1, 32'h11111111, 32'h22222222, 0, 0, 0, 0);
        applyStimulus("hiloHold", 0, 0, 0, 0, 0, 32'h33333333, 32'h44444444, 0, 0, 0, 0);
        applyStimulus("hiloHold2", 0, 0, 0, 0, 0, 32'h55555555, 32'h66666666, 0, 0, 0, 0);

        applyStimulus("resetVsWrite", 1, 1, 9, 32'h9, 1, 32'h7, 32'h8, 1, 9, 1, 9);
        applyStimulus("r9AfterReset", 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 3);

        // Random traffic concentrated on a few indices so bypass and overlap hits are frequent.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ra1, ra2;
            wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            applyStimulus("random",
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 2) != 0,
                          wa, $urandom,
                          $urandom_range(0, 3) == 0, $urandom, $urandom,
                          $urandom_range(0, 4) != 0, ra1,
                          $urandom_range(0, 4) != 0, ra2);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
